// File: rtl/adc_spi_reader_pkg.sv
// Shared definitions for the serial ADC reader.
//   state_e        : reader FSM encodings
//   ADC_*          : default frame layout (16-bit frame, 4 zero lead bits,
//                    12 data bits), the same word layout the DAC writer uses
//   cnt_w()        : bits needed for a counter spanning 0..n-1 (min 1)
package adc_spi_reader_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_e;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_LEAD_BITS  = 4;
  localparam int ADC_DATA_BITS  = 12;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/adc_spi_reader_if.sv
// Bus between the ADC reader and its surroundings (ADC pins + sample output).
//   master : the reader (drives sck/cs_n and the parallel sample side)
//   slave  : ADC model / consumer (drives start and miso)
interface adc_spi_reader_if #(parameter int DATA_BITS = 12);
  logic                 start;
  logic                 miso;
  logic                 sck;
  logic                 cs_n;
  logic                 busy;
  logic [DATA_BITS-1:0] sample;
  logic                 sample_valid;
  logic                 lead_err;

  modport master (input start, miso,
                  output sck, cs_n, busy, sample, sample_valid, lead_err);
  modport slave  (output start, miso,
                  input sck, cs_n, busy, sample, sample_valid, lead_err);
endinterface

// File: rtl/adc_spi_reader_sck_divider.sv
// Serial clock generator: sck toggles every CLK_DIV clk cycles while en_i.
//   clk, rst     : system clock, synchronous active-high reset
//   en_i         : run the divider; when low sck parks high, counter clears
//   clr_i        : force the idle state this edge (ends a frame on sck high)
//   sck_o        : registered serial clock, idles high
//   rise_tick_o  : this edge drives sck 0->1
//   fall_tick_o  : this edge drives sck 1->0
module sck_divider
  import adc_spi_reader_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic sck_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);
  localparam int            CW   = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          wrap;

  // Ticks depend only on en_i and registers so clr_i may be derived from them.
  assign wrap        = en_i && (cnt_q == LAST);
  assign rise_tick_o = wrap && !sck_q;
  assign fall_tick_o = wrap &&  sck_q;
  assign sck_o       = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
      sck_d = 1'b1;
    end else if (wrap) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sck_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end
endmodule

// File: rtl/adc_spi_reader.sv
// SPI master reading one AD7476-style frame per start request.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : adc_spi_reader_if.master
//              start in, miso in, sck/cs_n out, busy out,
//              sample/sample_valid/lead_err out (all registered)
// miso is captured on the edge that raises sck. Leading bits are ORed into
// lead_err, the next DATA_BITS bits shift in MSB-first, trailing bits drop.
module adc_spi_reader
  import adc_spi_reader_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int FRAME_BITS   = ADC_FRAME_BITS,
  parameter int LEAD_BITS    = ADC_LEAD_BITS,
  parameter int DATA_BITS    = ADC_DATA_BITS,
  parameter int QUIET_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  adc_spi_reader_if.master  bus
);
  localparam int            BW    = cnt_w(FRAME_BITS + 1);
  localparam int            QW    = cnt_w(QUIET_CYCLES);
  localparam logic [BW-1:0] NBITS = BW'(FRAME_BITS);
  localparam logic [BW-1:0] LEADN = BW'(LEAD_BITS);
  localparam logic [BW-1:0] DATAE = BW'(LEAD_BITS + DATA_BITS);
  localparam logic [QW-1:0] QLAST = QW'(QUIET_CYCLES - 1);

  state_e               state_q, state_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [QW-1:0]        quiet_q, quiet_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 lacc_q, lacc_d;
  logic                 cs_n_q, cs_n_d;
  logic                 busy_q, busy_d;
  logic [DATA_BITS-1:0] sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic                 lerr_q, lerr_d;

  logic div_en, rise_tick, fall_tick, done, sck;

  assign div_en = (state_q == SETUP) || (state_q == SHIFT);
  // After the last bit, the fall tick that would start another bit ends the frame
  // instead; clr keeps sck high so no extra edge appears.
  assign done   = (state_q == SHIFT) && fall_tick && (bit_q == NBITS);

  sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk         (clk),
    .rst         (rst),
    .en_i        (div_en),
    .clr_i       (done),
    .sck_o       (sck),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    quiet_d  = quiet_q;
    data_d   = data_q;
    lacc_d   = lacc_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    lerr_d   = lerr_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = SETUP;
        cs_n_d  = 1'b0;
        busy_d  = 1'b1;
        bit_d   = '0;
        data_d  = '0;
        lacc_d  = 1'b0;
      end
      // The divider's first fall tick marks the end of the cs_n setup time.
      SETUP: if (fall_tick) state_d = SHIFT;
      SHIFT: begin
        if (rise_tick && (bit_q != NBITS)) begin
          bit_d = bit_q + BW'(1);
          if (bit_q < LEADN)      lacc_d = lacc_q | bus.miso;
          else if (bit_q < DATAE) data_d = {data_q[DATA_BITS-2:0], bus.miso};
        end
        if (done) begin
          state_d  = QUIET;
          cs_n_d   = 1'b1;
          sample_d = data_q;
          lerr_d   = lacc_q;
          valid_d  = 1'b1;
          quiet_d  = '0;
        end
      end
      QUIET: if (quiet_q == QLAST) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end else begin
        quiet_d = quiet_q + QW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      quiet_q  <= '0;
      data_q   <= '0;
      lacc_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      quiet_q  <= quiet_d;
      data_q   <= data_d;
      lacc_q   <= lacc_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      lerr_q   <= lerr_d;
    end
  end

  assign bus.sck          = sck;
  assign bus.cs_n         = cs_n_q;
  assign bus.busy         = busy_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.lead_err     = lerr_q;
endmodule

// File: tb/tb_adc_spi_reader.sv
module tb_adc_spi_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  adc_spi_reader_if #(.DATA_BITS(12)) b0 ();
  adc_spi_reader_if #(.DATA_BITS(12)) b1 ();

  adc_spi_reader #(.CLK_DIV(2)) dut0 (.clk(clk), .rst(rst0), .bus(b0));
  adc_spi_reader #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst1), .bus(b1));

  int checks = 0;
  int errors = 0;

  // ADC models: first bit presented when cs_n falls, next bit after each sck rise.
  logic [15:0] word0 = '0, word1 = '0;
  int idx0 = 0, idx1 = 0;
  always @(posedge b0.sck or posedge b0.cs_n) if (b0.cs_n) idx0 = 0; else idx0 = idx0 + 1;
  always @(posedge b1.sck or posedge b1.cs_n) if (b1.cs_n) idx1 = 0; else idx1 = idx1 + 1;
  assign b0.miso = (idx0 < 16) ? word0[15 - idx0] : 1'b0;
  assign b1.miso = (idx1 < 16) ? word1[15 - idx1] : 1'b0;

  // sck edge counters while selected, and sck-high-while-deselected monitor
  int falls0 = 0, rises0 = 0, viol0 = 0;
  always @(negedge b0.sck) if (b0.cs_n === 1'b0) falls0++;
  always @(posedge b0.sck) if (b0.cs_n === 1'b0) rises0++;
  always @(negedge clk) if (b0.cs_n === 1'b1 && b0.sck !== 1'b1) viol0++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic set_start(input bit which, input logic v);
    if (which) b1.start = v; else b0.start = v;
  endtask

  // Issues a start at the current negedge and follows the frame until busy
  // drops. n counts negedges after the accepting posedge.
  task automatic run_frame(input bit which, input logic [15:0] word,
                           input int pulse_a, input int pulse_b,
                           output int valid_lat, output int valid_n,
                           output int busy_len, output logic [11:0] smp,
                           output logic le, output bit timeout);
    logic bsy, vld;
    if (which) word1 = word; else word0 = word;
    set_start(which, 1'b1);
    valid_lat = -1; valid_n = 0; busy_len = 0; timeout = 1'b1;
    smp = 'x; le = 1'bx;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      set_start(which, (n == pulse_a) || (n == pulse_b));
      bsy = which ? b1.busy : b0.busy;
      vld = which ? b1.sample_valid : b0.sample_valid;
      if (vld === 1'b1) begin
        valid_n++;
        if (valid_lat < 0) valid_lat = n - 1;
        smp = which ? b1.sample : b0.sample;
        le  = which ? b1.lead_err : b0.lead_err;
      end
      if (bsy === 1'b1) busy_len++;
      else begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst0 = 1'b1; rst1 = 1'b1;
    b0.start = 1'b0; b1.start = 1'b0;
    repeat (3) @(negedge clk);
    checks += 12;
    if (b0.sck !== 1'b1)          begin errors++; $display("FAIL reset0_sck got %b exp 1", b0.sck); end
    if (b0.cs_n !== 1'b1)         begin errors++; $display("FAIL reset0_cs_n got %b exp 1", b0.cs_n); end
    if (b0.busy !== 1'b0)         begin errors++; $display("FAIL reset0_busy got %b exp 0", b0.busy); end
    if (b0.sample !== 12'h000)    begin errors++; $display("FAIL reset0_sample got %h exp 000", b0.sample); end
    if (b0.sample_valid !== 1'b0) begin errors++; $display("FAIL reset0_valid got %b exp 0", b0.sample_valid); end
    if (b0.lead_err !== 1'b0)     begin errors++; $display("FAIL reset0_lead_err got %b exp 0", b0.lead_err); end
    if (b1.sck !== 1'b1)          begin errors++; $display("FAIL reset1_sck got %b exp 1", b1.sck); end
    if (b1.cs_n !== 1'b1)         begin errors++; $display("FAIL reset1_cs_n got %b exp 1", b1.cs_n); end
    if (b1.busy !== 1'b0)         begin errors++; $display("FAIL reset1_busy got %b exp 0", b1.busy); end
    if (b1.sample !== 12'h000)    begin errors++; $display("FAIL reset1_sample got %h exp 000", b1.sample); end
    if (b1.sample_valid !== 1'b0) begin errors++; $display("FAIL reset1_valid got %b exp 0", b1.sample_valid); end
    if (b1.lead_err !== 1'b0)     begin errors++; $display("FAIL reset1_lead_err got %b exp 0", b1.lead_err); end
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int lat, vn, bl; logic [11:0] s; logic le; bit to;
    run_frame(1'b0, 16'h0A5C, 0, 0, lat, vn, bl, s, le, to);
    checks += 6;
    if (to)            begin errors++; $display("FAIL single_timeout busy never dropped"); end
    if (s !== 12'hA5C) begin errors++; $display("FAIL single_sample got %h exp a5c", s); end
    if (le !== 1'b0)   begin errors++; $display("FAIL single_lead_err got %b exp 0", le); end
    if (vn != 1)       begin errors++; $display("FAIL single_valid_count got %0d exp 1", vn); end
    if (lat != 66)     begin errors++; $display("FAIL single_valid_latency got %0d exp 66", lat); end
    if (bl != 70)      begin errors++; $display("FAIL single_busy_len got %0d exp 70", bl); end
    @(negedge clk);
    checks += 2;
    if (b0.sample !== 12'hA5C)    begin errors++; $display("FAIL single_hold got %h exp a5c", b0.sample); end
    if (b0.sample_valid !== 1'b0) begin errors++; $display("FAIL single_valid_low got %b exp 0", b0.sample_valid); end
  endtask

  task automatic test_lead_err;
    int lat, vn, bl; logic [11:0] s; logic le; bit to;
    run_frame(1'b0, 16'h4FFF, 0, 0, lat, vn, bl, s, le, to);
    checks += 3;
    if (s !== 12'hFFF) begin errors++; $display("FAIL lead_sample got %h exp fff", s); end
    if (le !== 1'b1)   begin errors++; $display("FAIL lead_err got %b exp 1", le); end
    if (vn != 1)       begin errors++; $display("FAIL lead_valid_count got %0d exp 1", vn); end
  endtask

  task automatic test_edge_count;
    int lat, vn, bl, f0, r0; logic [11:0] s; logic le; bit to;
    f0 = falls0; r0 = rises0;
    run_frame(1'b0, 16'h3123, 0, 0, lat, vn, bl, s, le, to);
    checks += 5;
    if (falls0 - f0 != 16) begin errors++; $display("FAIL edge_falls got %0d exp 16", falls0 - f0); end
    if (rises0 - r0 != 16) begin errors++; $display("FAIL edge_rises got %0d exp 16", rises0 - r0); end
    if (viol0 != 0)        begin errors++; $display("FAIL edge_sck_idle_low got %0d exp 0", viol0); end
    if (s !== 12'h123)     begin errors++; $display("FAIL edge_sample got %h exp 123", s); end
    if (le !== 1'b1)       begin errors++; $display("FAIL edge_lead_err got %b exp 1", le); end
  endtask

  task automatic test_start_gating;
    int rise_n[$]; int vcnt, bl, lat, vn; logic prev, to_b; bit to;
    logic [11:0] s; logic le;
    word0 = 16'h0ABC;
    b0.start = 1'b1;
    prev = b0.busy; vcnt = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (b0.busy === 1'b1 && prev !== 1'b1) rise_n.push_back(n);
      if (b0.sample_valid === 1'b1) begin
        vcnt++;
        checks++;
        if (b0.sample !== 12'hABC) begin errors++; $display("FAIL hold_sample got %h exp abc", b0.sample); end
      end
      prev = b0.busy;
    end
    b0.start = 1'b0;
    checks += 2;
    if (rise_n.size() != 3) begin errors++; $display("FAIL hold_frames got %0d exp 3", rise_n.size()); end
    if (vcnt != 2)          begin errors++; $display("FAIL hold_valids got %0d exp 2", vcnt); end
    for (int i = 1; i < rise_n.size(); i++) begin
      checks++;
      if (rise_n[i] - rise_n[i-1] != 71) begin
        errors++; $display("FAIL hold_period got %0d exp 71", rise_n[i] - rise_n[i-1]);
      end
    end
    to_b = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (b0.busy === 1'b0) begin to_b = 1'b0; break; end
    end
    checks++;
    if (to_b) begin errors++; $display("FAIL hold_drain busy got 1 exp 0"); end
    // Pulses during SHIFT (n=20) and QUIET (n=68) must be ignored.
    run_frame(1'b0, 16'h0765, 20, 68, lat, vn, bl, s, le, to);
    checks += 4;
    if (s !== 12'h765) begin errors++; $display("FAIL pulse_sample got %h exp 765", s); end
    if (vn != 1)       begin errors++; $display("FAIL pulse_valid_count got %0d exp 1", vn); end
    if (bl != 70)      begin errors++; $display("FAIL pulse_busy_len got %0d exp 70", bl); end
    if (lat != 66)     begin errors++; $display("FAIL pulse_valid_latency got %0d exp 66", lat); end
    vn = 0;
    repeat (5) begin
      @(negedge clk);
      if (b0.busy !== 1'b0) vn++;
    end
    checks++;
    if (vn != 0) begin errors++; $display("FAIL pulse_extra_frame busy cycles got %0d exp 0", vn); end
  endtask

  task automatic test_reset_mid;
    int lat, vn, bl, vbad; logic [11:0] s; logic le; bit to;
    word0 = 16'h0FFF;
    b0.start = 1'b1;
    vbad = 0;
    // Negedge n=31 falls in the sck-low half of bit 7.
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      b0.start = 1'b0;
      if (b0.sample_valid === 1'b1) vbad++;
    end
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    checks += 5;
    if (b0.cs_n !== 1'b1)      begin errors++; $display("FAIL midrst_cs_n got %b exp 1", b0.cs_n); end
    if (b0.sck !== 1'b1)       begin errors++; $display("FAIL midrst_sck got %b exp 1", b0.sck); end
    if (b0.busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b exp 0", b0.busy); end
    if (b0.sample !== 12'h000) begin errors++; $display("FAIL midrst_sample got %h exp 000", b0.sample); end
    if (b0.sample_valid !== 1'b0) vbad++;
    rst0 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (b0.sample_valid === 1'b1) vbad++;
    end
    if (vbad != 0) begin errors++; $display("FAIL midrst_valid got %0d pulses exp 0", vbad); end
    run_frame(1'b0, 16'h0C3A, 0, 0, lat, vn, bl, s, le, to);
    checks += 4;
    if (s !== 12'hC3A) begin errors++; $display("FAIL midrst_next_sample got %h exp c3a", s); end
    if (le !== 1'b0)   begin errors++; $display("FAIL midrst_next_lead got %b exp 0", le); end
    if (vn != 1)       begin errors++; $display("FAIL midrst_next_valid got %0d exp 1", vn); end
    if (bl != 70)      begin errors++; $display("FAIL midrst_next_busy got %0d exp 70", bl); end
  endtask

  task automatic test_div1;
    int lat, vn, bl; logic [11:0] s; logic le; bit to;
    run_frame(1'b1, 16'h0001, 0, 0, lat, vn, bl, s, le, to);
    checks += 6;
    if (to)            begin errors++; $display("FAIL div1_timeout busy never dropped"); end
    if (s !== 12'h001) begin errors++; $display("FAIL div1_sample got %h exp 001", s); end
    if (le !== 1'b0)   begin errors++; $display("FAIL div1_lead got %b exp 0", le); end
    if (vn != 1)       begin errors++; $display("FAIL div1_valid_count got %0d exp 1", vn); end
    if (lat != 33)     begin errors++; $display("FAIL div1_valid_latency got %0d exp 33", lat); end
    if (bl != 37)      begin errors++; $display("FAIL div1_busy_len got %0d exp 37", bl); end
    run_frame(1'b1, 16'h8800, 0, 0, lat, vn, bl, s, le, to);
    checks += 3;
    if (s !== 12'h800) begin errors++; $display("FAIL div1b_sample got %h exp 800", s); end
    if (le !== 1'b1)   begin errors++; $display("FAIL div1b_lead got %b exp 1", le); end
    if (bl != 37)      begin errors++; $display("FAIL div1b_busy_len got %0d exp 37", bl); end
  endtask

  initial begin
    b0.start = 1'b0; b1.start = 1'b0;
    rst0 = 1'b1; rst1 = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_lead_err();
    test_edge_count();
    test_start_gating();
    test_reset_mid();
    test_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
